axis_bits_elastic_buffer: RTL and testbench
===========================================

Name: axis_bits_elastic_buffer

Overview:
Parametrised successor to the two-entry skid-buffer pipeline stage: an N-entry elastic buffer on a valid/ready bit stream with fully registered in_tready and out_tvalid. It decouples timing on both the forward and backward paths and keeps 100% throughput at any depth. It adds a synchronous flush, occupancy and almost-full outputs. It sits between DMA read-data return and write-data issue paths, where a single skid entry cannot absorb the bursts.

Parameters:
DATA_WIDTH, 64, payload width in bits (>=1)
DEPTH, 4, number of storage entries; power of two, >=2; elaboration error otherwise
ALMOST_FULL_THRESH, DEPTH-1, almost_full asserts when level >= this value; legal range 1..DEPTH

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous clear of all stored entries
in_tvalid  input  1  upstream valid
in_tready  output  1  upstream ready, registered
in_databits  input  DATA_WIDTH  upstream payload
out_tvalid  output  1  downstream valid, registered
out_tready  input  1  downstream ready
out_databits  output  DATA_WIDTH  downstream payload, driven from storage
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH, registered
almost_full  output  1  level >= ALMOST_FULL_THRESH, registered

Behaviour:
- Storage: DEPTH x DATA_WIDTH array. wptr/rptr are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
- empty: wptr == rptr. full: index bits equal and wrap bits differ.
- push = in_tvalid && in_tready. pop = out_tvalid && out_tready.
- Write occurs only on push. The array is not written on in_tready alone.
- Next-state pointers are computed combinationally from push/pop. Registered outputs are derived from the next-state values:
  - in_tready <= !full_next
  - out_tvalid <= !empty_next
  - level <= wptr_next - rptr_next
  - almost_full <= (level_next >= ALMOST_FULL_THRESH)
- out_databits = mem[rptr index]. Value is don't-care while out_tvalid = 0.
- Latency: a word pushed in cycle N is presented with out_tvalid = 1 in cycle N+1, when empty at cycle N.
- Throughput: one transfer per cycle sustained when in_tvalid and out_tready are both held high, for every DEPTH >= 2.
- Ordering: strict FIFO. No loss or duplication. out_databits is stable while out_tvalid && !out_tready.
- Full: in_tready is already low, so no push. A pop while full raises in_tready in the next cycle.
- Empty: out_tvalid is already low, so no pop. A push while empty raises out_tvalid in the next cycle.
- Simultaneous push and pop: level unchanged. in_tready and out_tvalid stay asserted.
- Pointer wrap: index wraps modulo DEPTH and the wrap bit toggles. No state beyond the pointers.
- flush: takes priority over push and pop in the same cycle.
  - Next cycle: wptr = rptr = 0, level = 0, out_tvalid = 0, almost_full = 0, in_tready = 1.
  - A word handshaked in the flush cycle is discarded.
  - A pop in the flush cycle is a legal completed transfer downstream.
- Reset:
  - Asserted: in_tready = 0, out_tvalid = 0, level = 0, almost_full = 0, pointers = 0. Array contents are not reset.
  - Deasserted: in_tready rises on the first clk edge after release.
  - Mid-operation assertion: all stored data is lost immediately; outputs go to reset values asynchronously.
- No combinational path from in_tvalid to out_tvalid, or from out_tready to in_tready.

Optional Feature:
AXIS_ELASTIC_BUFFER_STATS_EN
- Defined: adds two output ports, both cleared by rst only and not by flush.
  - stat_xfer_count (32 bits): increments on each pop.
  - stat_stall_count (32 bits): increments on each cycle with out_tvalid && !out_tready.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters do not exist. Functional behaviour is otherwise identical.

Test Plan:
- DEPTH=4; push 0x11,0x22,0x33,0x44 with out_tready=0 -> level=4, almost_full=1 from level 3, in_tready=0 the cycle after the 4th push; then out_tready=1 -> 0x11..0x44 in order, in_tready=1 one cycle after the first pop.
- Streaming: in_tvalid=out_tready=1 for 100 cycles with incrementing data -> 99 transfers, first output 1 cycle after first push, no bubbles, level constant at 1.
- Random in_tvalid/out_tready (50%) for 10000 words, DEPTH=8 -> scoreboard exact order; level never exceeds 8; out_databits stable during stalls.
- flush with level=3 while in_tvalid=1 and out_tready=1 -> next cycle level=0, out_tvalid=0, in_tready=1; the flush-cycle input word never appears at the output.
- rst asserted mid-burst with level=2 -> outputs go to 0 without a clock edge; after release, in_tready=1 on the first edge and the next pushed word 0xAB is the first word out.
- STATS_EN defined: 5 pops and 3 stall cycles -> stat_xfer_count=5, stat_stall_count=3; both unchanged by a following flush.

Source files
------------

// File: rtl/axis_bits_elastic_buffer.sv
// N-entry elastic buffer on a valid/ready bit stream with registered in_tready/out_tvalid,
// synchronous flush, occupancy and almost-full outputs. Optional stats via AXIS_ELASTIC_BUFFER_STATS_EN.
module axis_bits_elastic_buffer #(
    parameter int DATA_WIDTH         = 64,
    parameter int DEPTH              = 4,
    parameter int ALMOST_FULL_THRESH = DEPTH - 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_tvalid,
    output logic                    in_tready,
    input  logic [DATA_WIDTH-1:0]   in_databits,
    output logic                    out_tvalid,
    input  logic                    out_tready,
    output logic [DATA_WIDTH-1:0]   out_databits,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    almost_full
`ifdef AXIS_ELASTIC_BUFFER_STATS_EN
    ,
    output logic [31:0]             stat_xfer_count,
    output logic [31:0]             stat_stall_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_THRESH = PW'(ALMOST_FULL_THRESH);
    localparam logic [PW-1:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and >= 2");
    end
    if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("ALMOST_FULL_THRESH must be within 1..DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [PW-1:0]         level_q, level_d;
    logic                  in_tready_q, out_tvalid_q, almost_full_q;
    logic                  push_s, pop_s, full_d, empty_d;

    assign push_s       = in_tvalid && in_tready_q;
    assign pop_s        = out_tvalid_q && out_tready;
    assign in_tready    = in_tready_q;
    assign out_tvalid   = out_tvalid_q;
    assign level        = level_q;
    assign almost_full  = almost_full_q;
    assign out_databits = mem_q[rptr_q[AW-1:0]];

    // Next-state pointers; all registered status is derived from these so it is valid one cycle early.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = PTR_ZERO;
            rptr_d = PTR_ZERO;
        end else begin
            if (push_s) begin
                wptr_d = wptr_q + PTR_ONE;
            end else begin
                wptr_d = wptr_q;
            end
            if (pop_s) begin
                rptr_d = rptr_q + PTR_ONE;
            end else begin
                rptr_d = rptr_q;
            end
        end
        level_d = wptr_d - rptr_d;
        empty_d = (wptr_d == rptr_d);
        full_d  = (wptr_d[AW-1:0] == rptr_d[AW-1:0]) && (wptr_d[AW] != rptr_d[AW]);
    end

    // Pointer and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q        <= PTR_ZERO;
            rptr_q        <= PTR_ZERO;
            level_q       <= PTR_ZERO;
            in_tready_q   <= 1'b0;
            out_tvalid_q  <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            level_q       <= level_d;
            in_tready_q   <= !full_d;
            out_tvalid_q  <= !empty_d;
            almost_full_q <= (level_d >= AF_THRESH);
        end
    end

    // Storage write; a word accepted during flush is dropped, so it is not stored either.
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            mem_q[wptr_q[AW-1:0]] <= in_databits;
        end
    end

`ifdef AXIS_ELASTIC_BUFFER_STATS_EN
    logic [31:0] xfer_q, stall_q;

    assign stat_xfer_count  = xfer_q;
    assign stat_stall_count = stall_q;

    // Saturating transfer/stall counters, cleared only by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_q  <= 32'd0;
            stall_q <= 32'd0;
        end else begin
            if (pop_s && (xfer_q != 32'hFFFF_FFFF)) begin
                xfer_q <= xfer_q + 32'd1;
            end
            if (out_tvalid_q && !out_tready && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_bits_elastic_buffer.sv
// Self-checking bench: DEPTH=4 and DEPTH=8 instances compared every cycle against a queue model.
module tb_axis_bits_elastic_buffer;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          flush [2];
    logic          in_tvalid [2];
    logic          in_tready [2];
    logic          out_tvalid [2];
    logic          out_tready [2];
    logic          almost_full [2];
    logic [DW-1:0] in_data [2];
    logic [DW-1:0] out_data [2];
    logic [2:0]    level0;
    logic [3:0]    level1;
`ifdef AXIS_ELASTIC_BUFFER_STATS_EN
    logic [31:0]   sx [2];
    logic [31:0]   ss [2];
`endif

    axis_bits_elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .flush(flush[0]),
        .in_tvalid(in_tvalid[0]), .in_tready(in_tready[0]), .in_databits(in_data[0]),
        .out_tvalid(out_tvalid[0]), .out_tready(out_tready[0]), .out_databits(out_data[0]),
        .level(level0), .almost_full(almost_full[0])
`ifdef AXIS_ELASTIC_BUFFER_STATS_EN
        , .stat_xfer_count(sx[0]), .stat_stall_count(ss[0])
`endif
    );

    axis_bits_elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(8)) u8 (
        .clk(clk), .rst(rst), .flush(flush[1]),
        .in_tvalid(in_tvalid[1]), .in_tready(in_tready[1]), .in_databits(in_data[1]),
        .out_tvalid(out_tvalid[1]), .out_tready(out_tready[1]), .out_databits(out_data[1]),
        .level(level1), .almost_full(almost_full[1])
`ifdef AXIS_ELASTIC_BUFFER_STATS_EN
        , .stat_xfer_count(sx[1]), .stat_stall_count(ss[1])
`endif
    );

    // Reference model: contents as queues, plus event counters.
    logic [DW-1:0] mq0 [$];
    logic [DW-1:0] mq1 [$];
    bit            rdy_ok;
    int unsigned   xfer_m [2];
    int unsigned   stall_m [2];
    int unsigned   pops_cnt [2];
    int unsigned   push_cnt [2];
    int            tests = 0;
    int            fails = 0;

    function automatic int dep(int d);
        return (d == 0) ? 4 : 8;
    endfunction

    function automatic int msize(int d);
        return (d == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [31:0] mfront(int d);
        return (d == 0) ? mq0[0] : mq1[0];
    endfunction

    function automatic logic [31:0] lvl(int d);
        return (d == 0) ? 32'(level0) : 32'(level1);
    endfunction

    task automatic mclear(int d);
        if (d == 0) mq0.delete(); else mq1.delete();
    endtask

    task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s [depth %0d]: observed %0h expected %0h", tag, dep(d), obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk("in_tready", d, 32'(in_tready[d]), 32'(rdy_ok && (msize(d) < dep(d))));
            chk("out_tvalid", d, 32'(out_tvalid[d]), 32'(msize(d) > 0));
            chk("level", d, lvl(d), 32'(msize(d)));
            chk("almost_full", d, 32'(almost_full[d]), 32'(msize(d) >= dep(d) - 1));
            if (msize(d) > 0) chk("out_data", d, out_data[d], mfront(d));
`ifdef AXIS_ELASTIC_BUFFER_STATS_EN
            chk("stat_xfer", d, sx[d], xfer_m[d]);
            chk("stat_stall", d, ss[d], stall_m[d]);
`endif
        end
    endtask

    // One clock: check at negedge, apply the handshake rules to the model at posedge.
    task automatic cycle();
        bit pu [2];
        bit po [2];
        @(negedge clk);
        check_all();
        for (int d = 0; d < 2; d++) begin
            pu[d] = in_tvalid[d] && rdy_ok && (msize(d) < dep(d));
            po[d] = out_tready[d] && (msize(d) > 0);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (po[d]) begin xfer_m[d]++; pops_cnt[d]++; end
            if (pu[d]) push_cnt[d]++;
            if (msize(d) > 0 && !out_tready[d]) stall_m[d]++;
            if (flush[d]) begin
                mclear(d);
            end else begin
                if (po[d]) begin if (d == 0) void'(mq0.pop_front()); else void'(mq1.pop_front()); end
                if (pu[d]) begin if (d == 0) mq0.push_back(in_data[d]); else mq1.push_back(in_data[d]); end
            end
        end
        rdy_ok = 1'b1;
        #1;
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        rdy_ok = 1'b0;
        for (int d = 0; d < 2; d++) begin
            xfer_m[d]  = 0;
            stall_m[d] = 0;
        end
    endtask

    task automatic check_reset_outputs(string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_in_tready"}, d, 32'(in_tready[d]), 32'd0);
            chk({tag, "_out_tvalid"}, d, 32'(out_tvalid[d]), 32'd0);
            chk({tag, "_level"}, d, lvl(d), 32'd0);
            chk({tag, "_almost_full"}, d, 32'(almost_full[d]), 32'd0);
        end
    endtask

    initial begin
        int unsigned p0;
        int unsigned rx0;
        int unsigned tx0;

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            flush[d] = 1'b0; in_tvalid[d] = 1'b0; out_tready[d] = 1'b0; in_data[d] = 32'd0;
            pops_cnt[d] = 0; push_cnt[d] = 0;
        end
        model_reset();

        // Power-on reset, then release mid-cycle.
        @(posedge clk); #1;
        check_reset_outputs("por");
        @(negedge clk); #2;
        rst = 1'b0;
        chk("ready_low_before_edge", 0, 32'(in_tready[0]), 32'd0);
        @(posedge clk); rdy_ok = 1'b1; #1;
        chk("ready_first_edge", 0, 32'(in_tready[0]), 32'd1);

        // Fill DEPTH=4 with downstream stalled, then drain in order.
        out_tready[0] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_tvalid[0] = 1'b1;
            in_data[0]   = 32'(i * 32'h11);
            cycle();
        end
        in_tvalid[0] = 1'b0;
        chk("full_level", 0, lvl(0), 32'd4);
        chk("full_in_tready", 0, 32'(in_tready[0]), 32'd0);
        chk("full_almost_full", 0, 32'(almost_full[0]), 32'd1);
        cycle();
        out_tready[0] = 1'b1;
        cycle();
        chk("ready_after_first_pop", 0, 32'(in_tready[0]), 32'd1);
        repeat (4) cycle();

        // Streaming: 100 cycles of simultaneous valid/ready.
        p0 = pops_cnt[0];
        in_tvalid[0] = 1'b1;
        out_tready[0] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data[0] = 32'(i + 1);
            cycle();
        end
        in_tvalid[0] = 1'b0;
        chk("stream_transfers", 0, pops_cnt[0] - p0, 32'd99);
        chk("stream_level", 0, lvl(0), 32'd1);
        repeat (2) cycle();

        // Flush with level 3 while a push and a pop are both offered.
        out_tready[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_tvalid[0] = 1'b1;
            in_data[0]   = 32'hA0 + 32'(i);
            cycle();
        end
        chk("pre_flush_level", 0, lvl(0), 32'd3);
        flush[0] = 1'b1; in_tvalid[0] = 1'b1; out_tready[0] = 1'b1; in_data[0] = 32'hDEAD;
        cycle();
        flush[0] = 1'b0; in_tvalid[0] = 1'b0;
        chk("flush_level", 0, lvl(0), 32'd0);
        chk("flush_out_tvalid", 0, 32'(out_tvalid[0]), 32'd0);
        chk("flush_in_tready", 0, 32'(in_tready[0]), 32'd1);
        in_tvalid[0] = 1'b1; in_data[0] = 32'h55;
        cycle();
        in_tvalid[0] = 1'b0;
        chk("post_flush_word", 0, out_data[0], 32'h55);
        repeat (2) cycle();

        // Async reset mid-burst at level 2.
        out_tready[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_tvalid[0] = 1'b1;
            in_data[0]   = 32'hC0 + 32'(i);
            cycle();
        end
        in_tvalid[0] = 1'b0;
        chk("pre_reset_level", 0, lvl(0), 32'd2);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("async_rst");
        @(negedge clk); #2;
        rst = 1'b0;
        chk("ready_low_after_release", 0, 32'(in_tready[0]), 32'd0);
        @(posedge clk); rdy_ok = 1'b1; #1;
        chk("ready_first_edge_2", 0, 32'(in_tready[0]), 32'd1);
        in_tvalid[0] = 1'b1; in_data[0] = 32'hAB;
        cycle();
        in_tvalid[0] = 1'b0;
        chk("first_word_after_reset", 0, out_data[0], 32'hAB);
        out_tready[0] = 1'b1;
        repeat (2) cycle();

        // Randomized 50% valid/ready on DEPTH=8, 10000 words.
        rx0 = pops_cnt[1];
        tx0 = push_cnt[1];
        for (int c = 0; c < 60000 && (pops_cnt[1] - rx0) < 10000; c++) begin
            in_tvalid[1]  = ((push_cnt[1] - tx0) < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            out_tready[1] = 1'($urandom_range(0, 1));
            in_data[1]    = $urandom;
            cycle();
            if (lvl(1) > 32'd8) chk("rand_level_bound", 1, lvl(1), 32'd8);
        end
        in_tvalid[1] = 1'b0;
        chk("rand_words_out", 1, pops_cnt[1] - rx0, 32'd10000);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
